rv32i_wb_arbiter: RTL and testbench

RV32I_WB_ARBITER -- requirements
Module: rv32i_wb_arbiter

---
 rtl/rv32i_pkg.sv | 13 +
 rtl/rv32i_rr_arb2.sv | 48 ++++
 rtl/rv32i_wb_arbiter.sv | 112 +++++++++++
 tb/tb_rv32i_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and writeback requester encoding.
package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_GPR    = 32;

   typedef enum logic {
      REQ_LD = 1'b0,
      REQ_EX = 1'b1
   } req_e;

endpackage

// File: rtl/rv32i_rr_arb2.sv
// Two-way round-robin grant between load-return and execute writebacks.
module rv32i_rr_arb2
   import rv32i_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_ld,
   input  logic req_ex,
   output logic gnt_ld,
   output logic gnt_ex,
   output logic gnt_any,
   output req_e gnt_sel
);

   req_e ptr_q;
   req_e ptr_d;
   logic contested;

   always_comb begin
      gnt_ld    = 1'b0;
      gnt_ex    = 1'b0;
      ptr_d     = ptr_q;
      contested = req_ld & req_ex;
      if (!rst) begin
         if (contested) begin
            gnt_ld = (ptr_q == REQ_LD);
            gnt_ex = (ptr_q == REQ_EX);
            // only a contested grant hands priority to the other side
            ptr_d  = (ptr_q == REQ_LD) ? REQ_EX : REQ_LD;
         end else if (req_ld) begin
            gnt_ld = 1'b1;
         end else if (req_ex) begin
            gnt_ex = 1'b1;
         end
      end
      gnt_any = gnt_ld | gnt_ex;
      gnt_sel = gnt_ex ? REQ_EX : REQ_LD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= REQ_LD;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Writeback arbiter with pending-register scoreboard.
// Optional same-cycle bypass of the write port: define RV32I_WB_BYPASS_EN.
module rv32i_wb_arbiter
   import rv32i_pkg::*;
(
   input  logic                  I_CLK,
   input  logic                  I_RST,
   input  logic                  I_EX_VALID,
   output logic                  O_EX_READY,
   input  logic [REG_ADDR_W-1:0] I_EX_ADDR,
   input  logic [XLEN-1:0]       I_EX_DATA,
   input  logic                  I_LD_VALID,
   output logic                  O_LD_READY,
   input  logic [REG_ADDR_W-1:0] I_LD_ADDR,
   input  logic [XLEN-1:0]       I_LD_DATA,
   output logic                  O_WR_EN,
   output logic [REG_ADDR_W-1:0] O_DST_ADDR,
   output logic [XLEN-1:0]       O_DST_DATA,
   input  logic                  I_ISSUE_EN,
   input  logic [REG_ADDR_W-1:0] I_ISSUE_ADDR,
   input  logic [REG_ADDR_W-1:0] I_SRC1_ADDR,
   input  logic [REG_ADDR_W-1:0] I_SRC2_ADDR,
   output logic                  O_SRC1_BUSY,
   output logic                  O_SRC2_BUSY,
   output logic                  O_SRC1_FWD,
   output logic                  O_SRC2_FWD
);

   logic gnt_ld;
   logic gnt_ex;
   logic gnt_any;
   req_e gnt_sel;

   logic                  wr_en_q;
   logic                  wr_en_d;
   logic [REG_ADDR_W-1:0] dst_addr_q;
   logic [REG_ADDR_W-1:0] dst_addr_d;
   logic [XLEN-1:0]       dst_data_q;
   logic [XLEN-1:0]       dst_data_d;
   logic [NUM_GPR-1:0]    pending_q;
   logic [NUM_GPR-1:0]    pending_d;

   rv32i_rr_arb2 u_arb (
      .clk     (I_CLK),
      .rst     (I_RST),
      .req_ld  (I_LD_VALID),
      .req_ex  (I_EX_VALID),
      .gnt_ld  (gnt_ld),
      .gnt_ex  (gnt_ex),
      .gnt_any (gnt_any),
      .gnt_sel (gnt_sel)
   );

   assign O_EX_READY = gnt_ex;
   assign O_LD_READY = gnt_ld;

   always_comb begin
      wr_en_d    = 1'b0;
      dst_addr_d = dst_addr_q;
      dst_data_d = dst_data_q;
      if (gnt_any) begin
         dst_addr_d = (gnt_sel == REQ_EX) ? I_EX_ADDR : I_LD_ADDR;
         dst_data_d = (gnt_sel == REQ_EX) ? I_EX_DATA : I_LD_DATA;
         // x0 writes take the slot but never reach the register file
         wr_en_d    = (dst_addr_d != '0);
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (wr_en_q) begin
         pending_d[dst_addr_q] = 1'b0;
      end
      if (I_ISSUE_EN && (I_ISSUE_ADDR != '0)) begin
         pending_d[I_ISSUE_ADDR] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         wr_en_q    <= 1'b0;
         dst_addr_q <= '0;
         dst_data_q <= '0;
         pending_q  <= '0;
      end else begin
         wr_en_q    <= wr_en_d;
         dst_addr_q <= dst_addr_d;
         dst_data_q <= dst_data_d;
         pending_q  <= pending_d;
      end
   end

   assign O_WR_EN    = wr_en_q;
   assign O_DST_ADDR = dst_addr_q;
   assign O_DST_DATA = dst_data_q;

`ifdef RV32I_WB_BYPASS_EN
   assign O_SRC1_FWD  = wr_en_q && (dst_addr_q == I_SRC1_ADDR)
                        && (I_SRC1_ADDR != '0);
   assign O_SRC2_FWD  = wr_en_q && (dst_addr_q == I_SRC2_ADDR)
                        && (I_SRC2_ADDR != '0);
   assign O_SRC1_BUSY = pending_q[I_SRC1_ADDR] & ~O_SRC1_FWD;
   assign O_SRC2_BUSY = pending_q[I_SRC2_ADDR] & ~O_SRC2_FWD;
`else
   assign O_SRC1_FWD  = 1'b0;
   assign O_SRC2_FWD  = 1'b0;
   assign O_SRC1_BUSY = pending_q[I_SRC1_ADDR];
   assign O_SRC2_BUSY = pending_q[I_SRC2_ADDR];
`endif

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Randomized and directed bench for rv32i_wb_arbiter with a behavioural model.
module tb_rv32i_wb_arbiter;

`ifdef RV32I_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        ex_valid, ex_rdy, ld_valid, ld_rdy;
   logic [4:0]  ex_addr, ld_addr;
   logic [31:0] ex_data, ld_data;
   logic        wr_en;
   logic [4:0]  dst_addr;
   logic [31:0] dst_data;
   logic        issue_en;
   logic [4:0]  issue_addr, src1, src2;
   logic        busy1, busy2, fwd1, fwd2;

   int n_chk = 0;
   int n_err = 0;

   rv32i_wb_arbiter dut (
      .I_CLK        (clk),
      .I_RST        (rst),
      .I_EX_VALID   (ex_valid),
      .O_EX_READY   (ex_rdy),
      .I_EX_ADDR    (ex_addr),
      .I_EX_DATA    (ex_data),
      .I_LD_VALID   (ld_valid),
      .O_LD_READY   (ld_rdy),
      .I_LD_ADDR    (ld_addr),
      .I_LD_DATA    (ld_data),
      .O_WR_EN      (wr_en),
      .O_DST_ADDR   (dst_addr),
      .O_DST_DATA   (dst_data),
      .I_ISSUE_EN   (issue_en),
      .I_ISSUE_ADDR (issue_addr),
      .I_SRC1_ADDR  (src1),
      .I_SRC2_ADDR  (src2),
      .O_SRC1_BUSY  (busy1),
      .O_SRC2_BUSY  (busy2),
      .O_SRC1_FWD   (fwd1),
      .O_SRC2_FWD   (fwd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Model state: registered write, pending set, who wins the next tie.
   bit          m_ok = 1'b0;
   bit          m_wr = 1'b0;
   bit [4:0]    m_addr = '0;
   bit [31:0]   m_data = '0;
   bit [31:0]   m_pend = '0;
   bit          m_next_ex = 1'b0;
   bit          m_after_rst = 1'b0;

   initial begin
      bit e_ex, e_ld, e_f1, e_f2, e_b1, e_b2;
      forever begin
         @(negedge clk);
         e_ex = !rst && ex_valid && (!ld_valid || m_next_ex);
         e_ld = !rst && ld_valid && (!ex_valid || !m_next_ex);
         e_f1 = BYPASS && m_wr && (m_addr == src1) && (src1 != 0);
         e_f2 = BYPASS && m_wr && (m_addr == src2) && (src2 != 0);
         e_b1 = m_pend[src1] && !e_f1;
         e_b2 = m_pend[src2] && !e_f2;
         if (m_ok) begin
            chk("ex_ready", ex_rdy, e_ex);
            chk("ld_ready", ld_rdy, e_ld);
            chk("wr_en", wr_en, m_wr);
            if (m_wr || m_after_rst) begin
               chk("dst_addr", dst_addr, m_addr);
               chk("dst_data", dst_data, m_data);
            end
            chk("src1_busy", busy1, e_b1);
            chk("src2_busy", busy2, e_b2);
            chk("src1_fwd", fwd1, e_f1);
            chk("src2_fwd", fwd2, e_f2);
         end
         if (rst) begin
            m_ok        = 1'b1;
            m_wr        = 1'b0;
            m_addr      = '0;
            m_data      = '0;
            m_pend      = '0;
            m_next_ex   = 1'b0;
            m_after_rst = 1'b1;
         end else begin
            if (m_wr) m_pend[m_addr] = 1'b0;
            if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
            m_wr = 1'b0;
            if (e_ex || e_ld) begin
               m_addr = e_ex ? ex_addr : ld_addr;
               m_data = e_ex ? ex_data : ld_data;
               m_wr   = (m_addr != 0);
               if (ex_valid && ld_valid) m_next_ex = !m_next_ex;
            end
            m_after_rst = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid = 0; ex_addr = 0; ex_data = 0;
      ld_valid = 0; ld_addr = 0; ld_data = 0;
      issue_en = 0; issue_addr = 0;
      src1 = 0; src2 = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle();
      do_reset();
      #3;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_addr", dst_addr, 0);
      chk("rst_data", dst_data, 0);

      // single EX request
      ex_valid = 1; ex_addr = 5; ex_data = 32'hDEADBEEF;
      #3;
      chk("single_ex_ready", ex_rdy, 1);
      tick();
      idle();
      #3;
      chk("single_wr_en", wr_en, 1);
      chk("single_addr", dst_addr, 5);
      chk("single_data", dst_data, 32'hDEADBEEF);

      // contention after reset: LD first, then alternate
      do_reset();
      ex_valid = 1; ex_addr = 3; ld_valid = 1; ld_addr = 4;
      for (int i = 0; i < 4; i++) begin
         ex_data = 32'h3000_0000 + i;
         ld_data = 32'h4000_0000 + i;
         #3;
         chk("cont_ld_ready", ld_rdy, (i % 2 == 0));
         chk("cont_ex_ready", ex_rdy, (i % 2 == 1));
         if (i > 0) begin
            chk("cont_addr", dst_addr, (i % 2 == 1) ? 4 : 3);
            chk("cont_data", dst_data, (i % 2 == 1) ?
                32'h4000_0000 + i - 1 : 32'h3000_0000 + i - 1);
         end
         tick();
      end
      idle();
      #3;
      chk("cont_last_addr", dst_addr, 3);
      chk("cont_last_data", dst_data, 32'h3000_0003);

      // scoreboard set, clear, optional bypass
      tick();
      issue_en = 1; issue_addr = 7;
      tick();
      issue_en = 0; src1 = 7;
      #3;
      chk("sb_busy_issued", busy1, 1);
      ld_valid = 1; ld_addr = 7; ld_data = 32'h0000_0077;
      #3;
      chk("sb_ld_ready", ld_rdy, 1);
      tick();
      ld_valid = 0;
      #3;
      chk("sb_wr_en", wr_en, 1);
      chk("sb_busy_wr", busy1, BYPASS ? 0 : 1);
      chk("sb_fwd_wr", fwd1, BYPASS ? 1 : 0);
      tick();
      #3;
      chk("sb_busy_after", busy1, 0);

      // set wins over clear on the same register
      idle();
      issue_en = 1; issue_addr = 9;
      tick();
      issue_en = 0;
      ex_valid = 1; ex_addr = 9; ex_data = 32'h0000_0099;
      tick();
      ex_valid = 0;
      issue_en = 1; issue_addr = 9;
      #3;
      chk("coll_wr_addr", dst_addr, 9);
      tick();
      issue_en = 0; src1 = 9;
      #3;
      chk("coll_busy", busy1, 1);

      // x0 is never tracked nor written
      idle();
      issue_en = 1; issue_addr = 0;
      ex_valid = 1; ex_addr = 0; ex_data = 32'h1234_5678;
      #3;
      chk("x0_ex_ready", ex_rdy, 1);
      chk("x0_busy_pre", busy1, 0);
      tick();
      idle();
      #3;
      chk("x0_wr_en", wr_en, 0);
      chk("x0_busy", busy1, 0);
      chk("x0_fwd", fwd1, 0);

      // reset in the middle of traffic
      issue_en = 1; issue_addr = 13;
      tick();
      issue_addr = 12;
      ex_valid = 1; ex_addr = 12; ex_data = 32'hCAFE_0012;
      tick();
      rst = 1; issue_en = 0;
      ex_valid = 1; ld_valid = 1; ld_addr = 14;
      #3;
      chk("mrst_ex_ready", ex_rdy, 0);
      chk("mrst_ld_ready", ld_rdy, 0);
      tick();
      rst = 0;
      idle();
      src1 = 13; src2 = 12;
      #3;
      chk("mrst_wr_en", wr_en, 0);
      chk("mrst_busy1", busy1, 0);
      chk("mrst_busy2", busy2, 0);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst        = ($urandom_range(0, 63) == 0);
         ex_valid   = $urandom_range(0, 1);
         ld_valid   = $urandom_range(0, 1);
         ex_addr    = ($urandom_range(0, 3) == 0) ?
                      5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         ld_addr    = ($urandom_range(0, 3) == 0) ?
                      5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         ex_data    = $urandom;
         ld_data    = $urandom;
         issue_en   = ($urandom_range(0, 2) == 0);
         issue_addr = 5'($urandom_range(0, 7));
         src1       = 5'($urandom_range(0, 7));
         src2       = 5'($urandom_range(0, 7));
      end
      tick();
      idle();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
